sha256_iter_core: RTL

Iterative, multi-block SHA-256 compression engine with a valid/ready message input and a valid/ready digest output. It replaces the fully unrolled single-block hasher with a core that runs a parametrised number of rounds per clock and chains any number of 512-bit blocks. It also has an optional double-hash mode, SHA-256(SHA-256(m)), for the mining datapath. It sits between the nonce/header block builder and the target comparator.

---
 rtl/sha256_pkg.sv | 67 ++++++
 rtl/sha256_round.sv | 20 ++
 rtl/sha256_iter_core.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, word types and round helper functions
package sha256_pkg;

  typedef logic [31:0] word_t;
  // Eight-word vector; element 0 sits in the MSBs so {a..h} and {H0..H7} map directly.
  typedef logic [0:7][31:0] hvec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } core_state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam hvec_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
module sha256_round
  import sha256_pkg::*;
(
  input  hvec_t       vin,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output hvec_t       vout
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1   = vin[7] + big_sigma1(vin[4]) + ch(vin[4], vin[5], vin[6]) + k + w;
    t2   = big_sigma0(vin[0]) + maj(vin[0], vin[1], vin[2]);
    vout = {t1 + t2, vin[0], vin[1], vin[2], vin[3] + t1, vin[4], vin[5], vin[6]};
  end

endmodule

// File: rtl/sha256_iter_core.sv
// rtl/sha256_iter_core.sv - iterative multi-block SHA-256 core with optional double hash
module sha256_iter_core
  import sha256_pkg::*;
#(
  parameter int UNROLL    = 1,
  parameter int DOUBLE_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         in_double,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);

  localparam logic [5:0] STEP     = 6'(UNROLL);
  localparam logic [5:0] LAST_CNT = 6'(64 - UNROLL);

  core_state_t state;
  logic [5:0]  cnt;
  word_t       win [16];
  hvec_t       vars;
  hvec_t       hreg;
  logic        first_q;
  logic        last_q;
  logic        dbl_q;
  logic        pass_q;

  word_t       ext [16 + UNROLL];
  hvec_t       rnd_out;
  hvec_t       hbase;
  hvec_t       hsum;

  assign in_ready = rst_n && (state == ST_IDLE) && !out_valid;
  assign busy     = (state != ST_IDLE);

  // Extended schedule: later new words may depend on words produced earlier in the same edge.
  always_comb begin
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int j = 0; j < UNROLL; j++)
      ext[16 + j] = small_sigma1(ext[14 + j]) + ext[9 + j] + small_sigma0(ext[1 + j]) + ext[j];
  end

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    hvec_t vin;
    hvec_t vout;
    if (j == 0) begin : g_head
      assign vin = vars;
    end else begin : g_link
      assign vin = g_round[j-1].vout;
    end
    sha256_round u_round (
      .vin  (vin),
      .k    (K[cnt + 6'(j)]),
      .w    (win[j]),
      .vout (vout)
    );
  end

  assign rnd_out = g_round[UNROLL-1].vout;

  always_comb begin
    hbase = first_q ? IV : hreg;
    hsum  = '0;
    for (int i = 0; i < 8; i++) hsum[i] = hbase[i] + vars[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
      vars       <= '0;
      hreg       <= IV;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      dbl_q      <= 1'b0;
      pass_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_digest <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            for (int i = 0; i < 16; i++) win[i] <= in_block[511 - 32*i -: 32];
            vars    <= in_first ? IV : hreg;
            first_q <= in_first;
            last_q  <= in_last;
            dbl_q   <= in_double && (DOUBLE_EN != 0);
            pass_q  <= 1'b0;
            cnt     <= '0;
            state   <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          for (int i = 0; i < 16; i++) win[i] <= ext[i + UNROLL];
          vars <= rnd_out;
          cnt  <= cnt + STEP;
          if (cnt == LAST_CNT) state <= ST_ADD;
        end
        ST_ADD: begin
          hreg <= hsum;
          if (!last_q) begin
            state <= ST_IDLE;
          end else if (dbl_q && !pass_q) begin
            // Second pass hashes the 32-byte digest as a single padded block from IV.
            for (int i = 0; i < 8; i++) win[i] <= hsum[i];
            win[8] <= 32'h80000000;
            for (int i = 9; i < 15; i++) win[i] <= '0;
            win[15] <= 32'h00000100;
            vars    <= IV;
            first_q <= 1'b1;
            pass_q  <= 1'b1;
            cnt     <= '0;
            state   <= ST_ROUND;
          end else begin
            out_digest <= hsum;
            out_valid  <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
